// File: rtl/uart_tx_arb.sv
// Round-robin arbiter that multiplexes NREQ valid/ready byte streams onto one uart_tx input.
// The winner keeps the grant through tlast or MAXBURST bytes, then an IDLE cycle precedes the next grant.
module uart_tx_arb #(
    parameter int NREQ     = 4,
    parameter int DLEN     = 8,
    parameter int MAXBURST = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      i_req_tvalid,
    output logic [NREQ-1:0]      o_req_tready,
    input  logic [NREQ*DLEN-1:0] i_req_tdata,
    input  logic [NREQ-1:0]      i_req_tlast,
    output logic                 o_tvalid,
    input  logic                 i_tready,
    output logic [DLEN-1:0]      o_tdata,
    output logic [NREQ-1:0]      o_grant,
    output logic                 o_busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BW = $clog2(MAXBURST + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_XFER = 2'd1;

    logic [1:0]      state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [BW-1:0]   burst_ct_q, burst_ct_d;

    logic            found_s;
    logic [PW-1:0]   win_s;
    logic [DLEN-1:0] sel_data_s;
    logic            sel_valid_s;
    logic            sel_last_s;
    logic            beat_s;

    // Pick the first requesting port at or after ptr, wrapping around
    always_comb begin
        found_s = 1'b0;
        win_s   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found_s && i_req_tvalid[PW'((int'(ptr_q) + i) % NREQ)]) begin
                found_s = 1'b1;
                win_s   = PW'((int'(ptr_q) + i) % NREQ);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Select the owner's data/valid/last through the one-hot grant
    always_comb begin
        sel_data_s  = '0;
        sel_valid_s = |(i_req_tvalid & grant_q);
        sel_last_s  = |(i_req_tlast & grant_q);
        for (int k = 0; k < NREQ; k++) begin
            if (grant_q[k]) begin
                sel_data_s = sel_data_s | i_req_tdata[k*DLEN +: DLEN];
            end else begin
                sel_data_s = sel_data_s;
            end
        end
    end

    // Zero-latency pass-through while a grant is held; everything quiet otherwise
    always_comb begin
        o_tvalid     = 1'b0;
        o_tdata      = '0;
        o_req_tready = '0;
        beat_s       = 1'b0;
        case (state_q)
            ST_XFER: begin
                o_tvalid     = sel_valid_s;
                o_tdata      = sel_data_s;
                o_req_tready = grant_q & {NREQ{i_tready}};
                beat_s       = sel_valid_s & i_tready;
            end
            default: begin
                o_tvalid = 1'b0;
            end
        endcase
    end

    // Grant / release sequencing; tlast and the burst limit share one release path
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        burst_ct_d = burst_ct_q;
        case (state_q)
            ST_IDLE: begin
                if (found_s) begin
                    state_d    = ST_XFER;
                    grant_d    = NREQ'(1) << win_s;
                    ptr_d      = PW'((int'(win_s) + 1) % NREQ);
                    burst_ct_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_XFER: begin
                if (beat_s && (sel_last_s || burst_ct_q == BW'(MAXBURST - 1))) begin
                    state_d    = ST_IDLE;
                    grant_d    = '0;
                    burst_ct_d = '0;
                end else if (beat_s) begin
                    burst_ct_d = burst_ct_q + BW'(1);
                end else begin
                    burst_ct_d = burst_ct_q;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                grant_d    = '0;
                burst_ct_d = '0;
`ifndef SYNTHESIS
                $error("uart_tx_arb: invalid state %0d", state_q);
`endif
            end
        endcase
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            grant_q    <= '0;
            burst_ct_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            burst_ct_q <= burst_ct_d;
        end
    end

    assign o_grant = grant_q;
    assign o_busy  = (state_q == ST_XFER);

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed self-checking bench for uart_tx_arb (NREQ=4, DLEN=8, MAXBURST=16).
module tb_uart_tx_arb;

    localparam int NREQ     = 4;
    localparam int DLEN     = 8;
    localparam int MAXBURST = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      i_req_tvalid;
    logic [NREQ-1:0]      o_req_tready;
    logic [NREQ*DLEN-1:0] i_req_tdata;
    logic [NREQ-1:0]      i_req_tlast;
    logic                 o_tvalid;
    logic                 i_tready;
    logic [DLEN-1:0]      o_tdata;
    logic [NREQ-1:0]      o_grant;
    logic                 o_busy;

    int checks = 0;
    int errors = 0;

    uart_tx_arb #(.NREQ(NREQ), .DLEN(DLEN), .MAXBURST(MAXBURST)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_req_tvalid (i_req_tvalid),
        .o_req_tready (o_req_tready),
        .i_req_tdata  (i_req_tdata),
        .i_req_tlast  (i_req_tlast),
        .o_tvalid     (o_tvalid),
        .i_tready     (i_tready),
        .o_tdata      (o_tdata),
        .o_grant      (o_grant),
        .o_busy       (o_busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_ports();
        i_req_tvalid = '0;
        i_req_tdata  = '0;
        i_req_tlast  = '0;
    endtask

    task automatic set_port(input int k, input logic v, input logic [7:0] d, input logic l);
        i_req_tvalid[k]        = v;
        i_req_tdata[k*8 +: 8]  = d;
        i_req_tlast[k]         = l;
    endtask

    task automatic do_reset();
        clear_ports();
        i_tready = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_ports();
        i_req_tvalid = 4'hF;
        i_req_tlast  = 4'hF;
        i_req_tdata  = 32'hDEADBEEF;
        i_tready     = 1'b1;
        tick();
        tick();
        checks++;
        if (o_grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got %b exp 0000", o_grant); end
        checks++;
        if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", o_busy); end
        checks++;
        if (o_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b exp 0", o_tvalid); end
        checks++;
        if (o_tdata !== 8'h00) begin errors++; $display("FAIL reset_tdata got %h exp 00", o_tdata); end
        checks++;
        if (o_req_tready !== 4'b0000) begin errors++; $display("FAIL reset_req_tready got %b exp 0000", o_req_tready); end
        clear_ports();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        // ptr is 0 out of reset; port2 alone sends A1,A2,A3(last)
        set_port(2, 1'b1, 8'hA1, 1'b0);
        settle();
        checks++;
        if (o_grant !== 4'b0000 || o_tvalid !== 1'b0 || o_tdata !== 8'h00) begin
            errors++; $display("FAIL single_idle got grant=%b tvalid=%b tdata=%h exp 0000/0/00", o_grant, o_tvalid, o_tdata);
        end
        tick();
        checks++;
        if (o_grant !== 4'b0100 || o_busy !== 1'b1 || o_tvalid !== 1'b1 || o_tdata !== 8'hA1 || o_req_tready !== 4'b0100) begin
            errors++; $display("FAIL single_b0 got grant=%b busy=%b tvalid=%b tdata=%h rdy=%b exp 0100/1/1/a1/0100",
                               o_grant, o_busy, o_tvalid, o_tdata, o_req_tready);
        end
        tick();
        set_port(2, 1'b1, 8'hA2, 1'b0);
        settle();
        checks++;
        if (o_grant !== 4'b0100 || o_tdata !== 8'hA2) begin
            errors++; $display("FAIL single_b1 got grant=%b tdata=%h exp 0100/a2", o_grant, o_tdata);
        end
        tick();
        set_port(2, 1'b1, 8'hA3, 1'b1);
        settle();
        checks++;
        if (o_grant !== 4'b0100 || o_tdata !== 8'hA3 || o_req_tready !== 4'b0100) begin
            errors++; $display("FAIL single_b2 got grant=%b tdata=%h rdy=%b exp 0100/a3/0100", o_grant, o_tdata, o_req_tready);
        end
        tick();
        // Back to IDLE; ports 0 and 3 now tie, ptr=3 must favour port3
        set_port(2, 1'b0, 8'h00, 1'b0);
        set_port(0, 1'b1, 8'h30, 1'b1);
        set_port(3, 1'b1, 8'h03, 1'b1);
        settle();
        checks++;
        if (o_grant !== 4'b0000 || o_busy !== 1'b0 || o_tvalid !== 1'b0) begin
            errors++; $display("FAIL single_release got grant=%b busy=%b tvalid=%b exp 0000/0/0", o_grant, o_busy, o_tvalid);
        end
        tick();
        checks++;
        if (o_grant !== 4'b1000 || o_tdata !== 8'h03 || o_req_tready !== 4'b1000) begin
            errors++; $display("FAIL ptr_after_port2 got grant=%b tdata=%h rdy=%b exp 1000/03/1000", o_grant, o_tdata, o_req_tready);
        end
        tick();
        set_port(3, 1'b0, 8'h00, 1'b0);
        settle();
        checks++;
        if (o_grant !== 4'b0000) begin errors++; $display("FAIL single_bubble got %b exp 0000", o_grant); end
        tick();
        checks++;
        if (o_grant !== 4'b0001 || o_tdata !== 8'h30) begin
            errors++; $display("FAIL single_port0 got grant=%b tdata=%h exp 0001/30", o_grant, o_tdata);
        end
        tick();
        clear_ports();
        settle();
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int k = 0; k < NREQ; k++) set_port(k, 1'b1, 8'(8'h40 + k), 1'b1);
        settle();
        for (int n = 0; n < 5; n++) begin
            checks++;
            if (o_grant !== 4'b0000 || o_busy !== 1'b0) begin
                errors++; $display("FAIL rr_bubble%0d got grant=%b busy=%b exp 0000/0", n, o_grant, o_busy);
            end
            tick();
            checks++;
            if (o_grant !== 4'(1 << (n % 4)) || o_tdata !== 8'(8'h40 + (n % 4)) || o_req_tready !== 4'(1 << (n % 4))) begin
                errors++; $display("FAIL rr_grant%0d got grant=%b tdata=%h rdy=%b exp %b/%h",
                                   n, o_grant, o_tdata, o_req_tready, 4'(1 << (n % 4)), 8'(8'h40 + (n % 4)));
            end
            tick();
        end
        clear_ports();
        settle();
    endtask

    task automatic test_burst_limit();
        int p1_idx;
        logic p0_pend, p3_pend;
        logic [3:0] exp_grant;
        logic [7:0] exp_data;
        logic [3:0] acc;
        p1_idx = 0; p0_pend = 1'b0; p3_pend = 1'b0;
        do_reset();
        for (int c = 0; c < 27; c++) begin
            if (c == 1) begin p0_pend = 1'b1; p3_pend = 1'b1; end
            set_port(1, p1_idx < 20, 8'(8'h10 + p1_idx), p1_idx == 19);
            set_port(0, p0_pend, 8'h30, 1'b1);
            set_port(3, p3_pend, 8'h33, 1'b1);
            settle();
            exp_data = 8'h00;
            if (c >= 1 && c <= 16) begin exp_grant = 4'b0010; exp_data = 8'(8'h10 + c - 1); end
            else if (c == 18) begin exp_grant = 4'b1000; exp_data = 8'h33; end
            else if (c == 20) begin exp_grant = 4'b0001; exp_data = 8'h30; end
            else if (c >= 22 && c <= 25) begin exp_grant = 4'b0010; exp_data = 8'(8'h20 + c - 22); end
            else exp_grant = 4'b0000;
            checks++;
            if (o_grant !== exp_grant || o_tdata !== exp_data) begin
                errors++; $display("FAIL burst_c%0d got grant=%b tdata=%h exp %b/%h", c, o_grant, o_tdata, exp_grant, exp_data);
            end
            acc = o_req_tready & i_req_tvalid;
            tick();
            if (acc[1]) p1_idx++;
            if (acc[0]) p0_pend = 1'b0;
            if (acc[3]) p3_pend = 1'b0;
        end
        checks++;
        if (p1_idx != 20) begin errors++; $display("FAIL burst_bytes got %0d exp 20", p1_idx); end
        clear_ports();
        settle();
    endtask

    task automatic test_backpressure();
        int idx;
        logic [3:0] exp_grant, exp_rdy;
        logic [7:0] exp_data;
        logic acc;
        idx = 0;
        do_reset();
        for (int c = 0; c < 106; c++) begin
            i_tready = !(c >= 3 && c <= 102);
            set_port(2, idx < 4, 8'(8'hB0 + idx), idx == 3);
            settle();
            exp_grant = (c >= 1 && c <= 104) ? 4'b0100 : 4'b0000;
            exp_rdy   = (c == 1 || c == 2 || c == 103 || c == 104) ? 4'b0100 : 4'b0000;
            if (c == 1) exp_data = 8'hB0;
            else if (c == 2) exp_data = 8'hB1;
            else if (c >= 3 && c <= 103) exp_data = 8'hB2;
            else if (c == 104) exp_data = 8'hB3;
            else exp_data = 8'h00;
            checks++;
            if (o_grant !== exp_grant || o_req_tready !== exp_rdy || o_tdata !== exp_data) begin
                errors++; $display("FAIL bp_c%0d got grant=%b rdy=%b tdata=%h exp %b/%b/%h",
                                   c, o_grant, o_req_tready, o_tdata, exp_grant, exp_rdy, exp_data);
            end
            acc = o_req_tready[2] & i_req_tvalid[2];
            tick();
            if (acc) idx++;
        end
        i_tready = 1'b1;
        clear_ports();
        settle();
    endtask

    task automatic test_owner_gap();
        int idx;
        logic p3_pend;
        logic [3:0] exp_grant;
        logic exp_valid;
        logic [3:0] acc;
        idx = 0; p3_pend = 1'b0;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            if (c == 1) p3_pend = 1'b1;
            set_port(0, (idx < 3) && !(c >= 2 && c <= 6), 8'(8'hC0 + idx), idx == 2);
            set_port(3, p3_pend, 8'h3C, 1'b1);
            settle();
            if (c >= 1 && c <= 8) exp_grant = 4'b0001;
            else if (c == 10) exp_grant = 4'b1000;
            else exp_grant = 4'b0000;
            exp_valid = (c == 1 || c == 7 || c == 8 || c == 10);
            checks++;
            if (o_grant !== exp_grant || o_tvalid !== exp_valid) begin
                errors++; $display("FAIL gap_c%0d got grant=%b tvalid=%b exp %b/%b", c, o_grant, o_tvalid, exp_grant, exp_valid);
            end
            if (c == 7 || c == 8 || c == 10) begin
                checks++;
                if (o_tdata !== ((c == 7) ? 8'hC1 : (c == 8) ? 8'hC2 : 8'h3C)) begin
                    errors++; $display("FAIL gap_data_c%0d got %h", c, o_tdata);
                end
            end
            acc = o_req_tready & i_req_tvalid;
            tick();
            if (acc[0]) idx++;
            if (acc[3]) p3_pend = 1'b0;
        end
        clear_ports();
        settle();
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            set_port(1, 1'b1, 8'(8'h50 + c), 1'b0);
            tick();
        end
        settle();
        checks++;
        if (o_grant !== 4'b0010 || o_tvalid !== 1'b1) begin
            errors++; $display("FAIL rstmid_pre got grant=%b tvalid=%b exp 0010/1", o_grant, o_tvalid);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (o_grant !== 4'b0000 || o_busy !== 1'b0 || o_tvalid !== 1'b0 || o_tdata !== 8'h00 || o_req_tready !== 4'b0000) begin
            errors++; $display("FAIL rstmid_outputs got grant=%b busy=%b tvalid=%b tdata=%h rdy=%b exp all zero",
                               o_grant, o_busy, o_tvalid, o_tdata, o_req_tready);
        end
        tick();
        rst = 1'b0;
        for (int k = 0; k < NREQ; k++) set_port(k, 1'b1, 8'(8'h60 + k), 1'b1);
        settle();
        checks++;
        if (o_grant !== 4'b0000) begin errors++; $display("FAIL rstmid_idle got %b exp 0000", o_grant); end
        tick();
        checks++;
        if (o_grant !== 4'b0001 || o_tdata !== 8'h60) begin
            errors++; $display("FAIL rstmid_tie got grant=%b tdata=%h exp 0001/60", o_grant, o_tdata);
        end
        clear_ports();
        tick();
    endtask

    initial begin
        rst = 1'b1;
        i_tready = 1'b1;
        clear_ports();
        test_reset();
        test_single();
        test_round_robin();
        test_burst_limit();
        test_backpressure();
        test_owner_gap();
        test_reset_mid_packet();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
